neuron_mac_unit: RTL and testbench

Single-neuron multiply-accumulate engine that consumes one layer-0 weight column from a per-neuron weight BRAM and the matching input-activation buffer. On START it walks addresses 0..N_IN-1 and accumulates W·X in a wide accumulator. It then adds the neuron bias, rescales, saturates and optionally applies ReLU, and presents a 16-bit signed activation with a one-cycle DONE pulse. It sits directly downstream of the 28×16-bit weight BRAMs and drives their ADDR/EN. The BRAM WE is tied 0 at the instantiation site.

---
 rtl/neuron_mac_unit_if.sv | 35 +++
 rtl/neuron_mac_unit.sv | 160 ++++++++++++++++
 tb/tb_neuron_mac_unit.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/neuron_mac_unit_if.sv
// ----------------------------------------------------------------------------
// neuron_mac_unit_if
//   Bundles the control handshake and the shared weight/input memory bus of
//   one neuron MAC engine.
//
//   Control : start, bias -> engine ; busy, done, y <- engine
//   Memory  : mem_addr, mem_en <- engine ; w_do, x_do -> engine
//
//   modport slave  : the MAC engine's view.
//   modport master : the surrounding logic's view (sequencer + BRAMs).
// ----------------------------------------------------------------------------
interface neuron_mac_unit_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
);
  logic              start;
  logic [DATA_W-1:0] bias;      // signed, fixed point
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_en;
  logic [DATA_W-1:0] w_do;      // signed weight
  logic [DATA_W-1:0] x_do;      // signed input activation
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] y;         // signed result

  modport slave (
    input  start, bias, w_do, x_do,
    output mem_addr, mem_en, busy, done, y
  );

  modport master (
    output start, bias, w_do, x_do,
    input  mem_addr, mem_en, busy, done, y
  );
endinterface

// File: rtl/neuron_mac_unit.sv
// ----------------------------------------------------------------------------
// neuron_mac_unit
//   Single-neuron multiply-accumulate engine. On start it walks addresses
//   0..N_IN-1 of the weight BRAM and input buffer, accumulates w*x in an
//   ACC_W-bit accumulator, adds the bias, rescales by FRAC_BITS (floor),
//   saturates to DATA_W bits, optionally applies ReLU and pulses done.
//
//   Ports:
//     clk    : clock, all state updates on posedge
//     rst_n  : asynchronous active-low reset
//     bus    : neuron_mac_unit_if.slave (start/bias/busy/done/y and the
//              shared mem_addr/mem_en/w_do/x_do memory bus)
//
//   Timing: start sampled at edge c0, addresses issued after c0..c(N_IN-1),
//   last accumulate at c(N_IN), y/done at c(N_IN+1).
// ----------------------------------------------------------------------------
module neuron_mac_unit #(
  parameter int N_IN      = 28,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 40,
  parameter bit RELU      = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  neuron_mac_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_IN - 1);

  // Saturation bounds expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] Y_MAX =
    $signed({{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] Y_MIN =
    $signed({{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}});

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q;
  logic        [DATA_W-1:0]  bias_q;
  logic        [ADDR_W-1:0]  addr_q;
  logic                      en_q;
  logic                      busy_q;
  logic                      done_q;
  logic        [DATA_W-1:0]  y_q;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    bias_ext;
  logic signed [ACC_W-1:0]    sum;
  logic signed [ACC_W-1:0]    scaled;
  logic        [DATA_W-1:0]  y_next;

  // --------------------------------------------------------------------------
  // Datapath arithmetic
  // --------------------------------------------------------------------------
  assign prod     = $signed(bus.w_do) * $signed(bus.x_do);
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  // Bias is aligned to the product's 2*FRAC_BITS scaling before the add.
  assign bias_ext = $signed({{(ACC_W-DATA_W){bias_q[DATA_W-1]}}, bias_q}) <<< FRAC_BITS;
  assign sum      = acc_q + bias_ext;
  // Arithmetic right shift gives floor rounding toward -inf.
  assign scaled   = sum >>> FRAC_BITS;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    y_next = scaled[DATA_W-1:0];
    if (scaled > Y_MAX) begin
      y_next = Y_MAX[DATA_W-1:0];
    end else if (scaled < Y_MIN) begin
      y_next = Y_MIN[DATA_W-1:0];
    end
    // Sign of the saturated value equals the sign of scaled.
    if (RELU && scaled[ACC_W-1]) begin
      y_next = '0;
    end
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      // The edge that sees the last address still issued also consumes its
      // data, so leave RUN right there.
      RUN:     if (addr_q == LAST_ADDR) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registered datapath and outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      bias_q <= '0;
      addr_q <= '0;
      en_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      y_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            acc_q  <= '0;
            bias_q <= bus.bias;
            addr_q <= '0;
            en_q   <= 1'b1;
            busy_q <= 1'b1;
          end
        end
        RUN: begin
          // Memory data for the address issued one edge earlier is on w_do/x_do.
          acc_q <= acc_q + prod_ext;
          if (addr_q == LAST_ADDR) begin
            en_q <= 1'b0;
          end else begin
            addr_q <= addr_q + 1'b1;
          end
        end
        FINISH: begin
          y_q    <= y_next;
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_addr = addr_q;
  assign bus.mem_en   = en_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.y        = y_q;

endmodule

// File: tb/tb_neuron_mac_unit.sv
// ----------------------------------------------------------------------------
// tb_neuron_mac_unit
//   Two engines (RELU=1 and RELU=0) share one weight/input memory model and
//   the same stimulus. Expected results and DONE edges are queued when a run
//   is started; per-engine monitors pop and compare on every done pulse.
// ----------------------------------------------------------------------------
module tb_neuron_mac_unit;
  localparam int N_IN   = 28;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;
  localparam int LAT    = N_IN + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;                 // number of posedges so far
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] y;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [15:0] w;
    logic [15:0] x;
    logic [15:0] b;
    bit          ramp;     // w[i] = (i+1)*1.0 instead of constant w
    logic [15:0] e_relu;
    logic [15:0] e_lin;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];

  logic [15:0] wmem [N_IN];
  logic [15:0] xmem [N_IN];

  neuron_mac_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) b0 ();
  neuron_mac_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) b1 ();

  neuron_mac_unit #(.N_IN(N_IN), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                    .FRAC_BITS(8), .ACC_W(40), .RELU(1'b1)) dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b0.slave)
  );

  neuron_mac_unit #(.N_IN(N_IN), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                    .FRAC_BITS(8), .ACC_W(40), .RELU(1'b0)) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b1.slave)
  );

  // Memory model: data for the address seen at the negedge is valid at the
  // following posedge.
  always @(negedge clk) begin
    if (b0.mem_en) begin
      b0.w_do = wmem[b0.mem_addr];
      b0.x_do = xmem[b0.mem_addr];
    end
    if (b1.mem_en) begin
      b1.w_do = wmem[b1.mem_addr];
      b1.x_do = xmem[b1.mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor, RELU=1 engine: result, DONE edge, address sequence, enable count
  // --------------------------------------------------------------------------
  int en_cnt   = 0;
  int addr_err = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      en_cnt   = 0;
      addr_err = 0;
    end else begin
      if (b0.mem_en) begin
        if (int'(b0.mem_addr) != en_cnt) addr_err++;
        en_cnt++;
      end
      if (b0.done) begin
        if (q0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done0: got done with no pending run (t=%0t)", $time);
        end else begin
          e = q0.pop_front();
          check("y_relu1", 32'(b0.y), 32'(e.y));
          check("done_edge0", cyc, e.cyc);
          check("en_cycles", en_cnt, N_IN);
          check("addr_seq_errs", addr_err, 0);
          check("busy_at_done0", 32'(b0.busy), 0);
        end
        en_cnt   = 0;
        addr_err = 0;
      end
    end
  end

  // Monitor, RELU=0 engine
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && b1.done) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done1: got done with no pending run (t=%0t)", $time);
      end else begin
        e = q1.pop_front();
        check("y_relu0", 32'(b1.y), 32'(e.y));
        check("done_edge1", cyc, e.cyc);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_y0"},    32'(b0.y), 0);
    check({tag, "_done0"}, 32'(b0.done), 0);
    check({tag, "_busy0"}, 32'(b0.busy), 0);
    check({tag, "_en0"},   32'(b0.mem_en), 0);
    check({tag, "_addr0"}, 32'(b0.mem_addr), 0);
    check({tag, "_y1"},    32'(b1.y), 0);
    check({tag, "_busy1"}, 32'(b1.busy), 0);
    check({tag, "_en1"},   32'(b1.mem_en), 0);
  endtask

  // mode 0: plain run; 1: extra start pulses at c5 and c20; 2: reset at c10
  task automatic run_vec(input vec_t v, input int mode);
    int c0;
    for (int i = 0; i < N_IN; i++) begin
      wmem[i] = v.ramp ? 16'((i + 1) * 256) : v.w;
      xmem[i] = v.x;
    end
    @(negedge clk);
    b0.bias  = v.b;
    b1.bias  = v.b;
    b0.start = 1'b1;
    b1.start = 1'b1;
    c0 = cyc + 1;
    if (mode != 2) begin
      q0.push_back('{v.e_relu, c0 + LAT});
      q1.push_back('{v.e_lin,  c0 + LAT});
    end
    @(negedge clk);
    b0.start = 1'b0;
    b1.start = 1'b0;
    for (int k = 1; k <= N_IN + 3; k++) begin
      @(negedge clk);
      b0.start = (mode == 1) && (k == 4 || k == 19);
      b1.start = b0.start;
      if (mode == 2 && k == 10) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun_rst");
      end
    end
    if (mode == 2) begin
      @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  vec_t vecs [9];

  initial begin
    //            w        x        bias     ramp  relu=1   relu=0
    vecs[0] = '{16'h0100, 16'h0100, 16'h0000, 1'b0, 16'h1C00, 16'h1C00}; // 28.0
    vecs[1] = '{16'hFF00, 16'h0100, 16'h0000, 1'b0, 16'h0000, 16'hE400}; // -28.0
    vecs[2] = '{16'h7FFF, 16'h7FFF, 16'h0000, 1'b0, 16'h7FFF, 16'h7FFF}; // +sat
    vecs[3] = '{16'h8000, 16'h7FFF, 16'h0000, 1'b0, 16'h0000, 16'h8000}; // -sat
    vecs[4] = '{16'h0001, 16'h0001, 16'h0000, 1'b0, 16'h0000, 16'h0000}; // 28/256 floors to 0
    vecs[5] = '{16'hFFFF, 16'h0001, 16'h0000, 1'b0, 16'h0000, 16'hFFFF}; // -28/256 floors to -1 lsb
    vecs[6] = '{16'h0000, 16'h0100, 16'h0280, 1'b0, 16'h0280, 16'h0280}; // bias only
    vecs[7] = '{16'h0100, 16'h0100, 16'hE000, 1'b0, 16'h0000, 16'hFC00}; // 28-32 = -4
    vecs[8] = '{16'h0000, 16'h0010, 16'h0000, 1'b1, 16'h1960, 16'h1960}; // sum(1..28)/16 = 25.375

    rst_n    = 1'b0;
    b0.start = 1'b0;
    b1.start = 1'b0;
    b0.bias  = '0;
    b1.bias  = '0;
    b0.w_do  = '0;
    b0.x_do  = '0;
    b1.w_do  = '0;
    b1.x_do  = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], 0);
    run_vec(vecs[0], 1);        // extra starts while busy are ignored
    run_vec(vecs[6], 2);        // abandoned by reset, no done expected
    run_vec(vecs[0], 0);        // clean run after reset release

    repeat (5) @(negedge clk);
    check("pending_runs0", q0.size(), 0);
    check("pending_runs1", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
